// File: rtl/collision_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : collision_scheduler
// Purpose  : Shares one level_rom lookup port among NUM_REQ moving entities.
//            Once per frame it captures every requester's proposed position,
//            probes the four sprite corners against the wall map one lookup
//            at a time, and publishes a per-requester blocked mask.
// Revision : 1.0 - initial release
// ============================================================================
module collision_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int SPRITE_OFF = 31,
    parameter int X_LIMIT    = 639,
    parameter int Y_LIMIT    = 479
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_clk,
    input  logic [2:0]              room,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*10-1:0]   req_x,
    input  logic [NUM_REQ*10-1:0]   req_y,
    output logic [9:0]              rom_x,
    output logic [9:0]              rom_y,
    output logic [2:0]              rom_room,
    input  logic                    rom_wall,
    output logic [NUM_REQ-1:0]      blocked,
    output logic                    result_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0]       C_IDLE   = 3'd0;
    localparam logic [2:0]       C_ADDR   = 3'd1;
    localparam logic [2:0]       C_SAMPLE = 3'd2;
    localparam logic [2:0]       C_NEXT   = 3'd3;
    localparam logic [2:0]       C_DONE   = 3'd4;

    localparam logic [10:0]      C_OFF    = 11'(SPRITE_OFF);
    localparam logic [10:0]      C_XLIM   = 11'(X_LIMIT);
    localparam logic [10:0]      C_YLIM   = 11'(Y_LIMIT);
    localparam logic [IDX_W-1:0] C_LAST   = IDX_W'(NUM_REQ - 1);

    // Registered state
    logic [2:0]            state_q,   state_d;
    logic                  fclk_q;
    logic [NUM_REQ-1:0]    valid_q,   valid_d;
    logic [NUM_REQ*10-1:0] x_q,       x_d;
    logic [NUM_REQ*10-1:0] y_q,       y_d;
    logic [2:0]            room_q,    room_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic [1:0]            corner_q,  corner_d;
    logic [NUM_REQ-1:0]    scratch_q, scratch_d;
    logic [NUM_REQ-1:0]    blocked_q, blocked_d;
    logic                  oob_q,     oob_d;
    logic [9:0]            rom_x_q,   rom_x_d;
    logic [9:0]            rom_y_q,   rom_y_d;
    logic [2:0]            rom_room_q, rom_room_d;
    logic                  overrun_q, overrun_d;

    // Combinational helpers
    logic                  w_frame_edge;
    logic [9:0]            w_cur_x;
    logic [9:0]            w_cur_y;
    logic [10:0]           w_sum_x;
    logic [10:0]           w_sum_y;
    logic                  w_oob;
    logic [IDX_W-1:0]      w_next_idx;

    assign w_frame_edge = frame_clk & ~fclk_q;
    assign w_next_idx   = idx_q + IDX_W'(1);

    // Select the latched position of the requester currently being probed
    always_comb begin
        w_cur_x = '0;
        w_cur_y = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx_q == i[IDX_W-1:0]) begin
                w_cur_x = x_q[10*i +: 10];
                w_cur_y = y_q[10*i +: 10];
            end
        end
    end

    // Corner address: bit 0 of corner selects the far X, bit 1 the far Y.
    // The 11-bit sums catch both off-screen corners and 10-bit wrap-around.
    always_comb begin
        w_sum_x = {1'b0, w_cur_x} + (corner_q[0] ? C_OFF : 11'd0);
        w_sum_y = {1'b0, w_cur_y} + (corner_q[1] ? C_OFF : 11'd0);
        w_oob   = (w_sum_x > C_XLIM) || (w_sum_y > C_YLIM);
    end

    // Scan sequencer: capture, probe corners, step requesters, publish
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        x_d        = x_q;
        y_d        = y_q;
        room_d     = room_q;
        idx_d      = idx_q;
        corner_d   = corner_q;
        scratch_d  = scratch_q;
        blocked_d  = blocked_q;
        oob_d      = oob_q;
        rom_x_d    = rom_x_q;
        rom_y_d    = rom_y_q;
        rom_room_d = rom_room_q;
        overrun_d  = overrun_q;

        case (state_q)
            C_IDLE: begin
                if (w_frame_edge) begin
                    valid_d   = req_valid;
                    x_d       = req_x;
                    y_d       = req_y;
                    room_d    = room;
                    scratch_d = '0;
                    idx_d     = '0;
                    corner_d  = 2'd0;
                    state_d   = req_valid[0] ? C_ADDR : C_NEXT;
                end
            end
            C_ADDR: begin
                rom_x_d    = w_sum_x[9:0];
                rom_y_d    = w_sum_y[9:0];
                rom_room_d = room_q;
                oob_d      = w_oob;
                state_d    = C_SAMPLE;
            end
            C_SAMPLE: begin
                if (rom_wall || oob_q) begin
                    // First hit decides the requester; skip its other corners
                    scratch_d[idx_q] = 1'b1;
                    state_d          = C_NEXT;
                end else if (corner_q == 2'd3) begin
                    state_d = C_NEXT;
                end else begin
                    corner_d = corner_q + 2'd1;
                    state_d  = C_ADDR;
                end
            end
            C_NEXT: begin
                corner_d = 2'd0;
                if (idx_q == C_LAST) begin
                    // Mask becomes visible in the same cycle as result_valid
                    blocked_d = scratch_q;
                    state_d   = C_DONE;
                end else begin
                    idx_d   = w_next_idx;
                    state_d = valid_q[w_next_idx] ? C_ADDR : C_NEXT;
                end
            end
            C_DONE: begin
                state_d = C_IDLE;
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase

        if (w_frame_edge && (state_q != C_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= C_IDLE;
            fclk_q     <= 1'b0;
            valid_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            room_q     <= 3'd0;
            idx_q      <= '0;
            corner_q   <= 2'd0;
            scratch_q  <= '0;
            blocked_q  <= '0;
            oob_q      <= 1'b0;
            rom_x_q    <= 10'd0;
            rom_y_q    <= 10'd0;
            rom_room_q <= 3'd0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fclk_q     <= frame_clk;
            valid_q    <= valid_d;
            x_q        <= x_d;
            y_q        <= y_d;
            room_q     <= room_d;
            idx_q      <= idx_d;
            corner_q   <= corner_d;
            scratch_q  <= scratch_d;
            blocked_q  <= blocked_d;
            oob_q      <= oob_d;
            rom_x_q    <= rom_x_d;
            rom_y_q    <= rom_y_d;
            rom_room_q <= rom_room_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rom_x        = rom_x_q;
    assign rom_y        = rom_y_q;
    assign rom_room     = rom_room_q;
    assign blocked      = blocked_q;
    assign result_valid = (state_q == C_DONE);
    assign busy         = (state_q != C_IDLE);
    assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_collision_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_collision_scheduler
// Purpose  : Self-checking bench for collision_scheduler. A scan-level model
//            turns each captured frame into a list of expected cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_collision_scheduler;

    localparam int NR = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          frame_clk = 1'b0;
    logic [2:0]    room = 3'd0;
    logic [NR-1:0] req_valid = '0;
    logic [NR*10-1:0] req_x = '0;
    logic [NR*10-1:0] req_y = '0;
    logic [9:0]    rom_x;
    logic [9:0]    rom_y;
    logic [2:0]    rom_room;
    logic          rom_wall;
    logic [NR-1:0] blocked;
    logic          result_valid;
    logic          busy;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    collision_scheduler #(
        .NUM_REQ(NR), .SPRITE_OFF(31), .X_LIMIT(639), .Y_LIMIT(479)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .room(room),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .rom_x(rom_x), .rom_y(rom_y), .rom_room(rom_room), .rom_wall(rom_wall),
        .blocked(blocked), .result_valid(result_valid), .busy(busy),
        .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    // Wall map: room 7 is empty; other rooms have a 16px border and pillars
    function automatic logic wall_at(input int x, input int y, input int r);
        if (r == 7) return 1'b0;
        if (x < 16 || y < 16 || x >= 608 || y >= 448) return 1'b1;
        if (((x / 32) % 5 == 2) && ((y / 32) % 4 == 1)) return 1'b1;
        return 1'b0;
    endfunction

    assign rom_wall = wall_at(int'(rom_x), int'(rom_y), int'(rom_room));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // kind: 0 idle, 1 address, 2 sample, 3 next, 4 done
    typedef struct packed {
        logic [2:0] kind;
        logic [9:0] ax;
        logic [9:0] ay;
        logic [2:0] ar;
    } step_t;

    function automatic step_t mk(input int k, input int x, input int y, input int r);
        step_t s;
        s.kind = 3'(k);
        s.ax   = 10'(x);
        s.ay   = 10'(y);
        s.ar   = 3'(r);
        return s;
    endfunction

    step_t     sq[$];
    step_t     cur = '0;
    logic [NR-1:0] pend_mask = '0;
    logic [NR-1:0] m_blocked = '0;
    logic      m_ovr = 1'b0;
    logic      fprev = 1'b0;
    logic      edge_s;
    int        m_rx = 0, m_ry = 0, m_rr = 0;

    always @(posedge Clk) begin
        if (Reset) begin
            sq.delete();
            cur       = '0;
            m_blocked = '0;
            m_ovr     = 1'b0;
            fprev     = 1'b0;
            m_rx = 0; m_ry = 0; m_rr = 0;
        end else begin
            edge_s = frame_clk && !fprev;
            fprev  = frame_clk;
            if (cur.kind != 0) begin
                if (edge_s) m_ovr = 1'b1;
                if (sq.size() > 0) cur = sq.pop_front();
                else cur = '0;
            end else if (edge_s) begin
                pend_mask = '0;
                for (int i = 0; i < NR; i++) begin
                    if (req_valid[i]) begin
                        for (int c = 0; c < 4; c++) begin
                            int cx, cy;
                            logic hit;
                            cx  = int'(req_x[10*i +: 10]) + ((c % 2 == 1) ? 31 : 0);
                            cy  = int'(req_y[10*i +: 10]) + ((c >= 2) ? 31 : 0);
                            sq.push_back(mk(1, 0, 0, 0));
                            sq.push_back(mk(2, cx % 1024, cy % 1024, int'(room)));
                            hit = (cx > 639) || (cy > 479) ||
                                  wall_at(cx % 1024, cy % 1024, int'(room));
                            if (hit) begin
                                pend_mask[i] = 1'b1;
                                break;
                            end
                        end
                    end
                    sq.push_back(mk(3, 0, 0, 0));
                end
                sq.push_back(mk(4, 0, 0, 0));
                cur = sq.pop_front();
            end
            if (cur.kind == 2) begin
                m_rx = int'(cur.ax);
                m_ry = int'(cur.ay);
                m_rr = int'(cur.ar);
            end
            if (cur.kind == 4) m_blocked = pend_mask;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge Clk) begin
        if (started) begin
            chk("busy",         int'(busy),         int'(cur.kind != 0));
            chk("result_valid", int'(result_valid), int'(cur.kind == 4));
            chk("blocked",      int'(blocked),      int'(m_blocked));
            chk("overrun",      int'(overrun),      int'(m_ovr));
            chk("rom_x",        int'(rom_x),        m_rx);
            chk("rom_y",        int'(rom_y),        m_ry);
            chk("rom_room",     int'(rom_room),     m_rr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_req(input int i, input int x, input int y);
        req_x[10*i +: 10] = 10'(x);
        req_y[10*i +: 10] = 10'(y);
    endtask

    // Fire one frame edge and wait for result_valid; pins latency and mask
    task automatic run_scan(input string nm, input int exp_cyc,
                            input logic [NR-1:0] exp_mask,
                            input int pulse_at, input int chg_at);
        int n;
        bit got;
        @(negedge Clk);
        frame_clk = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge Clk);
            n++;
            if (result_valid) got = 1'b1;
            if (n == 1) frame_clk = 1'b0;
            if (n == pulse_at) frame_clk = 1'b1;
            if (n == pulse_at + 1) frame_clk = 1'b0;
            if (n == chg_at) req_x = ~req_x;
        end
        chk({nm, "_latency"}, n, exp_cyc);
        chk({nm, "_mask"}, int'(blocked), int'(exp_mask));
        @(negedge Clk);
        chk({nm, "_idle_after"}, int'(busy), 0);
    endtask

    initial begin
        int pulses;
        repeat (3) @(negedge Clk);
        started = 1'b1;
        chk("reset_blocked", int'(blocked), 0);
        chk("reset_busy",    int'(busy), 0);
        chk("reset_rv",      int'(result_valid), 0);
        chk("reset_ovr",     int'(overrun), 0);
        chk("reset_romxy",   int'({rom_x, rom_y, rom_room}), 0);
        Reset = 1'b0;

        // Player alone in open floor: 8 probe cycles + 4 NEXT, DONE on 13
        room = 3'd0; req_valid = 4'b0001; set_req(0, 336, 400);
        run_scan("open_player", 13, 4'b0000, -5, -5);

        // Corner 0 hits the border wall: 1 probe pair + 4 NEXT, DONE on 7
        set_req(0, 0, 0);
        run_scan("corner_hit", 7, 4'b0001, -5, -5);

        // Empty room, far X off-screen on corner 1
        room = 3'd7; req_valid = 4'b0010; set_req(1, 620, 100);
        run_scan("oob_x", 9, 4'b0010, -5, -5);

        // All four open: 36 scan cycles then DONE; second edge mid-scan
        room = 3'd0; req_valid = 4'b1111;
        set_req(0, 336, 400); set_req(1, 100, 100);
        set_req(2, 200, 200); set_req(3, 400, 256);
        run_scan("all_open", 37, 4'b0000, 10, -5);
        chk("overrun_set", int'(overrun), 1);
        run_scan("all_open2", 37, 4'b0000, -5, -5);
        chk("overrun_sticky", int'(overrun), 1);

        // Reset during requester 2's first SAMPLE (cycle 20 after capture)
        @(negedge Clk);
        frame_clk = 1'b1;
        pulses = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge Clk);
            if (result_valid) pulses++;
            if (n == 1) frame_clk = 1'b0;
            if (n == 20) Reset = 1'b1;
            if (n == 22) Reset = 1'b0;
        end
        chk("abort_no_pulse", pulses, 0);
        chk("abort_outputs", int'({blocked, busy, overrun, rom_x, rom_y, rom_room}), 0);
        run_scan("after_abort", 37, 4'b0000, -5, -5);
        chk("after_abort_ovr", int'(overrun), 0);

        // Sparse requests, req3 on the border wall, inputs changed mid-scan
        req_valid = 4'b1010; set_req(1, 100, 100); set_req(3, 0, 200);
        run_scan("sparse", 15, 4'b1000, -5, 3);

        // Randomized traffic, model checks every cycle
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge Clk);
            if ($urandom_range(0, 19) == 0) frame_clk = ~frame_clk;
            if ($urandom_range(0, 3) == 0) begin
                int i;
                i = $urandom_range(0, NR - 1);
                set_req(i, $urandom_range(0, 680), $urandom_range(0, 520));
            end
            if ($urandom_range(0, 15) == 0) req_valid = 4'($urandom);
            if ($urandom_range(0, 63) == 0) room = 3'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                int i;
                i = $urandom_range(0, NR - 1);
                set_req(i, $urandom_range(990, 1023), $urandom_range(0, 1023));
            end
            Reset = ($urandom_range(0, 799) == 0);
        end
        Reset = 1'b0;
        repeat (5) @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
